// File: rtl/cpu_branch_predictor.sv
// cpu_branch_predictor: fetch-stage next-PC predictor (BTB + direction counters + RAS + static BTFN) with a one-entry-per-cycle flush sweep
// Ports: i_clock/i_reset_n clock and async active-low reset; i_pc + i_fetch_fire + decode flags + B/J immediates in,
// o_pc_hint/o_hint_src combinational prediction out; i_resolve* train from execute; i_flush starts the sweep,
// o_busy flags it; o_hit_count/o_miss_count count resolves without/with mispredict.
module cpu_branch_predictor #(
  parameter int ENTRIES   = 64,
  parameter int CTR_BITS  = 2,
  parameter int RAS_DEPTH = 8,
  parameter bit STATS_EN  = 1
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [31:0] i_pc,
  input  logic        i_fetch_fire,
  input  logic        i_is_jal,
  input  logic        i_is_call,
  input  logic        i_is_return,
  input  logic        i_is_jump_conditional,
  input  logic [31:0] i_inst_B_imm,
  input  logic [31:0] i_inst_J_imm,
  output logic [31:0] o_pc_hint,
  output logic [2:0]  o_hint_src,
  input  logic        i_resolve,
  input  logic [31:0] i_resolve_pc,
  input  logic        i_resolve_taken,
  input  logic [31:0] i_resolve_target,
  input  logic        i_resolve_conditional,
  input  logic        i_resolve_mispredict,
  input  logic        i_flush,
  output logic        o_busy,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam int RAS_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = RAS_W + 1;
  localparam logic [CTR_BITS-1:0] CTR_WT = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state;
  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] unc_mem;
  logic [TAG_W-1:0] tag_mem [ENTRIES];
  logic [31:0] tgt_mem [ENTRIES];
  logic [CTR_BITS-1:0] ctr_mem [ENTRIES];
  logic [31:0] ras [RAS_DEPTH];
  logic [RAS_W-1:0] ras_ptr, ras_up, ras_dn;
  logic [CNT_W-1:0] ras_cnt;
  logic [IDX_W-1:0] sweep_idx, f_idx, r_idx;
  logic [TAG_W-1:0] f_tag, r_tag;
  logic [CTR_BITS-1:0] r_ctr, r_ctr_nxt;
  logic f_take, ras_ok, static_bt, train, r_hit, push, pop;
  assign f_idx = i_pc[IDX_W+1:2];
  assign f_tag = i_pc[31:IDX_W+2];
  assign r_idx = i_resolve_pc[IDX_W+1:2];
  assign r_tag = i_resolve_pc[31:IDX_W+2];
  assign f_take = state == IDLE && valid[f_idx] && tag_mem[f_idx] == f_tag &&
                  (unc_mem[f_idx] || ctr_mem[f_idx][CTR_BITS-1]);
  assign ras_ok = i_is_return && ras_cnt != '0;
  assign static_bt = i_is_jump_conditional && i_inst_B_imm[31];
  assign o_pc_hint = f_take ? tgt_mem[f_idx] : ras_ok ? ras[ras_ptr] :
                     i_is_jal ? i_pc + i_inst_J_imm : static_bt ? i_pc + i_inst_B_imm : i_pc;
  assign o_hint_src = f_take ? 3'd1 : ras_ok ? 3'd2 : i_is_jal ? 3'd3 : static_bt ? 3'd4 : 3'd0;
  assign train = i_resolve && state == IDLE;
  assign r_hit = valid[r_idx] && tag_mem[r_idx] == r_tag;
  assign r_ctr = ctr_mem[r_idx];
  assign r_ctr_nxt = i_resolve_taken ? (r_ctr == CTR_MAX ? r_ctr : r_ctr + 1'b1)
                                     : (r_ctr == '0 ? r_ctr : r_ctr - 1'b1);
  assign ras_up = ras_ptr + 1'b1;
  assign ras_dn = ras_ptr - 1'b1;
  assign push = i_fetch_fire && i_is_call && !i_is_return;
  assign pop = i_fetch_fire && i_is_return && !i_is_call && ras_cnt != '0;
  always_ff @(posedge i_clock) begin
    if (train && r_hit) begin
      if (i_resolve_conditional) ctr_mem[r_idx] <= r_ctr_nxt;
      if (i_resolve_taken || !i_resolve_conditional) tgt_mem[r_idx] <= i_resolve_target;
    end else if (train && i_resolve_taken) begin
      tag_mem[r_idx] <= r_tag;
      tgt_mem[r_idx] <= i_resolve_target;
      unc_mem[r_idx] <= !i_resolve_conditional;
      ctr_mem[r_idx] <= CTR_WT;
    end
    // call+return overwrites the current top in place; a lone call writes above it
    if (i_fetch_fire && i_is_call) ras[i_is_return ? ras_ptr : ras_up] <= i_pc + 32'd4;
  end
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid <= '0;
      ras_ptr <= '0;
      ras_cnt <= '0;
      state <= IDLE;
      sweep_idx <= '0;
      o_busy <= 1'b0;
    end else begin
      if (train && !r_hit && i_resolve_taken) valid[r_idx] <= 1'b1;
      if (state == SWEEP) valid[sweep_idx] <= 1'b0;
      ras_ptr <= push ? ras_up : pop ? ras_dn : ras_ptr;
      ras_cnt <= i_flush ? '0 : push ? (ras_cnt == CNT_W'(RAS_DEPTH) ? ras_cnt : ras_cnt + 1'b1) :
                 pop ? ras_cnt - 1'b1 : ras_cnt;
      if (i_flush) begin
        state <= SWEEP;
        sweep_idx <= '0;
        o_busy <= 1'b1;
      end else if (state == SWEEP) begin
        sweep_idx <= sweep_idx + 1'b1;
        if (sweep_idx == IDX_W'(ENTRIES - 1)) begin
          state <= IDLE;
          o_busy <= 1'b0;
        end
      end
    end
  end
  if (STATS_EN) begin : g_stats
    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        o_hit_count <= '0;
        o_miss_count <= '0;
      end else if (i_resolve) begin
        if (i_resolve_mispredict) o_miss_count <= o_miss_count + 1'b1;
        else o_hit_count <= o_hit_count + 1'b1;
      end
    end
  end else begin : g_no_stats
    assign o_hit_count = '0;
    assign o_miss_count = '0;
  end
endmodule

// File: tb/tb_cpu_branch_predictor.sv
// tb_cpu_branch_predictor: directed stimulus checked against a behavioural predictor model every cycle plus literal expectations
module tb_cpu_branch_predictor;
  localparam int E = 64;
  localparam int CB = 2;
  localparam int RD = 8;
  logic clk = 0, rst_n = 0;
  logic [31:0] i_pc = 0, b_imm = 0, j_imm = 0, r_pc = 0, r_tgt = 0;
  logic fire = 0, is_jal = 0, is_call = 0, is_ret = 0, is_cond = 0;
  logic res = 0, r_taken = 0, r_cond = 0, r_mis = 0, flush = 0;
  logic [31:0] o_pc_hint, o_hit_count, o_miss_count;
  logic [2:0] o_hint_src;
  logic o_busy;
  int tests = 0, fails = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  cpu_branch_predictor #(.ENTRIES(E), .CTR_BITS(CB), .RAS_DEPTH(RD), .STATS_EN(1)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_pc(i_pc), .i_fetch_fire(fire), .i_is_jal(is_jal),
    .i_is_call(is_call), .i_is_return(is_ret), .i_is_jump_conditional(is_cond),
    .i_inst_B_imm(b_imm), .i_inst_J_imm(j_imm), .o_pc_hint(o_pc_hint), .o_hint_src(o_hint_src),
    .i_resolve(res), .i_resolve_pc(r_pc), .i_resolve_taken(r_taken), .i_resolve_target(r_tgt),
    .i_resolve_conditional(r_cond), .i_resolve_mispredict(r_mis), .i_flush(flush),
    .o_busy(o_busy), .o_hit_count(o_hit_count), .o_miss_count(o_miss_count));
  // behavioural model
  bit m_val [E];
  bit m_unc [E];
  logic [31:0] m_tag [E];
  logic [31:0] m_tgt [E];
  int m_ctr [E];
  logic [31:0] q [$];
  bit m_sweep = 0;
  int m_sidx = 0;
  logic [31:0] m_hits = 0, m_miss = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void m_lookup(output logic [31:0] h, output logic [2:0] s);
    int ix = int'((i_pc >> 2) % E);
    bit hit = !m_sweep && m_val[ix] && m_tag[ix] == i_pc / (4 * E);
    if (hit && (m_unc[ix] || m_ctr[ix] >= (1 << (CB - 1)))) begin h = m_tgt[ix]; s = 1; end
    else if (is_ret && q.size() > 0) begin h = q[$]; s = 2; end
    else if (is_jal) begin h = i_pc + j_imm; s = 3; end
    else if (is_cond && $signed(b_imm) < 0) begin h = i_pc + b_imm; s = 4; end
    else begin h = i_pc; s = 0; end
  endfunction
  task automatic model_step();
    int ix;
    if (!rst_n) begin
      foreach (m_val[i]) m_val[i] = 0;
      q.delete();
      m_sweep = 0;
      m_sidx = 0;
      m_hits = 0;
      m_miss = 0;
      return;
    end
    if (res) begin
      if (r_mis) m_miss++;
      else m_hits++;
      ix = int'((r_pc >> 2) % E);
      if (!m_sweep) begin
        if (m_val[ix] && m_tag[ix] == r_pc / (4 * E)) begin
          if (r_cond) m_ctr[ix] = r_taken ? (m_ctr[ix] < (1 << CB) - 1 ? m_ctr[ix] + 1 : m_ctr[ix])
                                          : (m_ctr[ix] > 0 ? m_ctr[ix] - 1 : 0);
          if (r_taken || !r_cond) m_tgt[ix] = r_tgt;
        end else if (r_taken) begin
          m_val[ix] = 1;
          m_tag[ix] = r_pc / (4 * E);
          m_tgt[ix] = r_tgt;
          m_unc[ix] = !r_cond;
          m_ctr[ix] = 1 << (CB - 1);
        end
      end
    end
    if (fire) begin
      if (is_call && is_ret) begin
        if (q.size() > 0) q[q.size() - 1] = i_pc + 4;
      end else if (is_call) begin
        q.push_back(i_pc + 4);
        if (q.size() > RD) void'(q.pop_front());
      end else if (is_ret && q.size() > 0) void'(q.pop_back());
    end
    if (flush) begin
      m_sweep = 1;
      m_sidx = 0;
      q.delete();
    end else if (m_sweep) begin
      m_val[m_sidx] = 0;
      if (m_sidx == E - 1) m_sweep = 0;
      else m_sidx++;
    end
  endtask
  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end
  initial forever begin
    logic [31:0] h;
    logic [2:0] s;
    @(negedge clk);
    if (chk_en) begin
      m_lookup(h, s);
      check("model_hint", o_pc_hint, h);
      check("model_src", {29'b0, o_hint_src}, {29'b0, s});
      check("model_busy", {31'b0, o_busy}, {31'b0, m_sweep});
      check("model_hits", o_hit_count, m_hits);
      check("model_miss", o_miss_count, m_miss);
    end
  end
  task automatic clr();
    i_pc = 0; b_imm = 0; j_imm = 0; r_pc = 0; r_tgt = 0; fire = 0; is_jal = 0; is_call = 0;
    is_ret = 0; is_cond = 0; res = 0; r_taken = 0; r_cond = 0; r_mis = 0; flush = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic cnd, input logic mis);
    r_pc = pc; r_taken = tk; r_tgt = tgt; r_cond = cnd; r_mis = mis; res = 1;
    step();
    res = 0;
  endtask
  task automatic lookup(input string nm, input logic [31:0] pc, input logic [31:0] eh, input logic [2:0] es);
    i_pc = pc;
    @(negedge clk);
    check({nm, "_hint"}, o_pc_hint, eh);
    check({nm, "_src"}, {29'b0, o_hint_src}, {29'b0, es});
    step();
  endtask
  task automatic fetch(input logic [31:0] pc, input logic c, input logic r);
    i_pc = pc; fire = 1; is_call = c; is_ret = r;
    step();
    fire = 0; is_call = 0; is_ret = 0;
  endtask
  task automatic ret_fire(input string nm, input logic [31:0] eh, input logic [2:0] es);
    i_pc = 32'h4000; is_ret = 1; fire = 1;
    @(negedge clk);
    check({nm, "_hint"}, o_pc_hint, eh);
    check({nm, "_src"}, {29'b0, o_hint_src}, {29'b0, es});
    step();
    is_ret = 0; fire = 0;
  endtask
  initial begin
    int n;
    bit done;
    clr();
    repeat (3) @(posedge clk);
    #1;
    i_pc = 32'h123;
    #1;
    check("rst_hint", o_pc_hint, 32'h123);
    check("rst_src", {29'b0, o_hint_src}, 0);
    check("rst_busy", {31'b0, o_busy}, 0);
    check("rst_hits", o_hit_count, 0);
    check("rst_miss", o_miss_count, 0);
    rst_n = 1;
    chk_en = 1;
    step();
    is_jal = 1; j_imm = 32'h40;
    lookup("jal", 32'h100, 32'h140, 3);
    is_jal = 0; is_cond = 1; b_imm = 32'hFFFF_FFF0;
    lookup("bwd", 32'h100, 32'hF0, 4);
    b_imm = 32'h10;
    lookup("fwd", 32'h100, 32'h100, 0);
    clr();
    resolve(32'h200, 1, 32'h80, 1, 1);
    lookup("btb_alloc", 32'h200, 32'h80, 1);
    resolve(32'h200, 0, 0, 1, 0);
    resolve(32'h200, 0, 0, 1, 0);
    lookup("btb_weak", 32'h200, 32'h200, 0);
    check("stat_miss", o_miss_count, 1);
    check("stat_hits", o_hit_count, 2);
    resolve(32'h200, 1, 32'h80, 1, 0);
    resolve(32'h200, 1, 32'h80, 1, 0);
    lookup("btb_retrain", 32'h200, 32'h80, 1);
    resolve(32'h300, 1, 32'h500, 1, 1);
    lookup("alias_old", 32'h200, 32'h200, 0);
    lookup("alias_new", 32'h300, 32'h500, 1);
    fetch(32'h1000, 1, 0);
    fetch(32'h2000, 1, 0);
    ret_fire("ras_top", 32'h2004, 2);
    ret_fire("ras_next", 32'h1004, 2);
    ret_fire("ras_empty", 32'h4000, 0);
    for (int k = 1; k <= RD + 1; k++) fetch(32'(k) * 32'h100, 1, 0);
    for (int k = RD + 1; k >= 2; k--) ret_fire("ras_lifo", 32'(k) * 32'h100 + 32'h4, 2);
    ret_fire("ras_drained", 32'h4000, 0);
    resolve(32'h10, 1, 32'hA0, 0, 0);
    resolve(32'h14, 1, 32'hB0, 0, 0);
    resolve(32'h18, 1, 32'hC0, 0, 0);
    lookup("pre_fl0", 32'h10, 32'hA0, 1);
    lookup("pre_fl1", 32'h14, 32'hB0, 1);
    lookup("pre_fl2", 32'h18, 32'hC0, 1);
    flush = 1;
    step();
    flush = 0;
    i_pc = 32'h10;
    r_pc = 32'h40; r_taken = 1; r_tgt = 32'h99; r_cond = 0; r_mis = 0; res = 1;
    n = 0;
    done = 0;
    for (int c = 0; c < 3 * E && !done; c++) begin
      @(negedge clk);
      if (c == 0) check("sweep_src", {29'b0, o_hint_src}, 0);
      if (o_busy) n++;
      else done = 1;
      if (!done) begin
        step();
        res = 0;
      end
    end
    check("busy_cycles", n, E);
    clr();
    step();
    lookup("post_fl0", 32'h10, 32'h10, 0);
    lookup("post_fl2", 32'h18, 32'h18, 0);
    lookup("no_alloc", 32'h40, 32'h40, 0);
    resolve(32'h10, 1, 32'hA0, 0, 0);
    lookup("retrain", 32'h10, 32'hA0, 1);
    flush = 1;
    step();
    flush = 0;
    repeat (5) step();
    i_pc = 32'h10;
    r_pc = 32'h200; r_taken = 1; r_tgt = 32'h80; r_cond = 1; r_mis = 1; res = 1;
    #2;
    rst_n = 0;
    #1;
    check("arst_busy", {31'b0, o_busy}, 0);
    check("arst_hits", o_hit_count, 0);
    check("arst_miss", o_miss_count, 0);
    check("arst_src", {29'b0, o_hint_src}, 0);
    check("arst_hint", o_pc_hint, 32'h10);
    clr();
    @(posedge clk);
    #3;
    rst_n = 1;
    step();
    lookup("after_rst0", 32'h10, 32'h10, 0);
    lookup("after_rst1", 32'h300, 32'h300, 0);
    lookup("after_rst2", 32'h200, 32'h200, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
